// File: rtl/alu_multicycle.sv
// Multi-cycle EX-stage ALU: one-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide producing a HI/LO result pair.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   in_valid / in_ready       operation handshake (in_ready = !busy)
//   A, B, aluctl              operands and op select
//   C, hi, ovf                registered result/LO, HI, signed overflow
//   ready                     one-cycle pulse when C/hi/ovf update
//   busy                      multiply/divide iteration in progress
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CTLW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [CTLW-1:0]  aluctl,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] hi,
    output logic             ovf,
    output logic             ready,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [CTLW-1:0] OP_ADD   = CTLW'(0);
    localparam logic [CTLW-1:0] OP_ADDU  = CTLW'(1);
    localparam logic [CTLW-1:0] OP_SUB   = CTLW'(2);
    localparam logic [CTLW-1:0] OP_SUBU  = CTLW'(3);
    localparam logic [CTLW-1:0] OP_AND   = CTLW'(4);
    localparam logic [CTLW-1:0] OP_OR    = CTLW'(5);
    localparam logic [CTLW-1:0] OP_XOR   = CTLW'(6);
    localparam logic [CTLW-1:0] OP_NOR   = CTLW'(7);
    localparam logic [CTLW-1:0] OP_SLL   = CTLW'(8);
    localparam logic [CTLW-1:0] OP_SRL   = CTLW'(9);
    localparam logic [CTLW-1:0] OP_SRA   = CTLW'(10);
    localparam logic [CTLW-1:0] OP_SLT   = CTLW'(11);
    localparam logic [CTLW-1:0] OP_SLTU  = CTLW'(12);
    localparam logic [CTLW-1:0] OP_MULT  = CTLW'(13);
    localparam logic [CTLW-1:0] OP_MULTU = CTLW'(14);
    localparam logic [CTLW-1:0] OP_DIV   = CTLW'(15);
    localparam logic [CTLW-1:0] OP_DIVU  = CTLW'(16);

    typedef enum logic {S_IDLE, S_ITER} state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic             ovf_q, ovf_d;
    logic             ready_q, ready_d;
    // acc: partial product high half / partial remainder
    // mq:  multiplier being consumed / dividend shifting out, quotient in
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             div_q, div_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] a_q, a_d;

    // One-cycle datapath
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] add_r, sub_r;
    logic             add_ovf, sub_ovf;
    logic             slt_b, sltu_b;

    assign shamt   = B[SW-1:0];
    assign add_r   = A + B;
    assign sub_r   = A - B;
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_r[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_r[WIDTH-1] != A[WIDTH-1]);
    assign slt_b   = $signed(A) < $signed(B);
    assign sltu_b  = A < B;

    // Operand magnitudes for the iterative unit
    logic             signed_op, is_div;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign signed_op = (aluctl == OP_MULT) || (aluctl == OP_DIV);
    assign is_div    = (aluctl == OP_DIV) || (aluctl == OP_DIVU);
    assign a_neg     = signed_op && A[WIDTH-1];
    assign b_neg     = signed_op && B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    // Multiply step: add multiplicand on mq[0], shift {acc,mq} right
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   madd;
    assign addend = mq_q[0] ? dvs_q : '0;
    assign madd   = {1'b0, acc_q} + {1'b0, addend};

    // Divide step: shift in next dividend bit, subtract if it fits.
    // acc < divisor always, so bit WIDTH of the difference is a clean borrow.
    logic [WIDTH:0]   shl, dif;
    logic             qbit;
    assign shl  = {acc_q, mq_q[WIDTH-1]};
    assign dif  = shl - {1'b0, dvs_q};
    assign qbit = !dif[WIDTH];

    logic [WIDTH-1:0]   nacc, nmq;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo, rem;

    assign nacc   = div_q ? (qbit ? dif[WIDTH-1:0] : shl[WIDTH-1:0])
                          : madd[WIDTH:1];
    assign nmq    = div_q ? {mq_q[WIDTH-2:0], qbit}
                          : {madd[0], mq_q[WIDTH-1:1]};
    assign prod   = {nacc, nmq};
    assign prod_s = negq_q ? -prod : prod;
    assign quo    = negq_q ? -nmq : nmq;
    assign rem    = negr_q ? -nacc : nacc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        hi_d    = hi_q;
        ovf_d   = ovf_q;
        ready_d = 1'b0;
        acc_d   = acc_q;
        mq_d    = mq_q;
        dvs_d   = dvs_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        a_d     = a_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    ready_d = 1'b1;
                    ovf_d   = 1'b0;
                    unique case (aluctl)
                        OP_ADD:   begin c_d = add_r; ovf_d = add_ovf; end
                        OP_ADDU:  c_d = add_r;
                        OP_SUB:   begin c_d = sub_r; ovf_d = sub_ovf; end
                        OP_SUBU:  c_d = sub_r;
                        OP_AND:   c_d = A & B;
                        OP_OR:    c_d = A | B;
                        OP_XOR:   c_d = A ^ B;
                        OP_NOR:   c_d = ~(A | B);
                        OP_SLL:   c_d = A << shamt;
                        OP_SRL:   c_d = A >> shamt;
                        OP_SRA:   c_d = $unsigned($signed(A) >>> shamt);
                        OP_SLT:   c_d = {{(WIDTH-1){1'b0}}, slt_b};
                        OP_SLTU:  c_d = {{(WIDTH-1){1'b0}}, sltu_b};
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            ready_d = 1'b0;
                            ovf_d   = ovf_q;
                            state_d = S_ITER;
                            cnt_d   = SW'(WIDTH-1);
                            acc_d   = '0;
                            mq_d    = a_mag;
                            dvs_d   = b_mag;
                            div_d   = is_div;
                            negq_d  = a_neg ^ b_neg;
                            negr_d  = a_neg;
                            dz_d    = (B == '0);
                            a_d     = A;
                        end
                        default:  c_d = '0;
                    endcase
                end
            end
            S_ITER: begin
                acc_d = nacc;
                mq_d  = nmq;
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    ready_d = 1'b1;
                    ovf_d   = 1'b0;
                    if (div_q) begin
                        if (dz_q) begin
                            c_d  = '1;
                            hi_d = a_q;
                        end else begin
                            c_d  = quo;
                            hi_d = rem;
                        end
                    end else begin
                        c_d  = prod_s[WIDTH-1:0];
                        hi_d = prod_s[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            c_q     <= '0;
            hi_q    <= '0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b0;
            acc_q   <= '0;
            mq_q    <= '0;
            dvs_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            hi_q    <= hi_d;
            ovf_q   <= ovf_d;
            ready_q <= ready_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            dvs_q   <= dvs_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            a_q     <= a_d;
        end
    end

    assign C        = c_q;
    assign hi       = hi_q;
    assign ovf      = ovf_q;
    assign ready    = ready_q;
    assign busy     = (state_q == S_ITER);
    assign in_ready = !busy;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: directed ops with hand-computed
// results, latency/busy windows, back-to-back accept and reset abort.
module tb_alu_multicycle;

    localparam logic [5:0] ADD = 6'd0, ADDU = 6'd1, SUB = 6'd2, SUBU = 6'd3;
    localparam logic [5:0] AND_ = 6'd4, OR_ = 6'd5, XOR_ = 6'd6, NOR_ = 6'd7;
    localparam logic [5:0] SLL = 6'd8, SRL = 6'd9, SRA = 6'd10;
    localparam logic [5:0] SLT = 6'd11, SLTU = 6'd12;
    localparam logic [5:0] MULT = 6'd13, MULTU = 6'd14, DIV = 6'd15, DIVU = 6'd16;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic [5:0]  aluctl;
    logic [31:0] C, hi;
    logic        ovf, ready, busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] c;
        logic [31:0] hi;
        logic        ovf;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    alu_multicycle dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .aluctl   (aluctl),
        .C        (C),
        .hi       (hi),
        .ovf      (ovf),
        .ready    (ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every ready pulse retires the oldest expected result
    always @(posedge clk) begin
        #1;
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ready: got C=%h hi=%h expected no pulse", C, hi);
            end else begin
                e = sb.pop_front();
                chk({e.nm, " C"}, C, e.c);
                chk({e.nm, " hi"}, hi, e.hi);
                chk({e.nm, " ovf"}, 32'(ovf), 32'(e.ovf));
            end
        end
    end

    // Drive one op now (caller controls the cycle), then watch latency and busy.
    // poke: cycle offset at which a stray in_valid is raised while busy.
    // abort_at: cycle offset at which rst is raised mid-iteration.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ec, input logic [31:0] eh, input logic eo,
                         input int lat, input int poke, input int abort_at, input string nm);
        int cyc;
        int bad;
        bit seen;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        aluctl   = op;
        A        = a;
        B        = b;
        in_valid = 1'b1;
        if (abort_at == 0) sb.push_back('{ec, eh, eo, nm});
        cyc  = 0;
        bad  = 0;
        seen = 1'b0;
        while (!seen && cyc < lat + 4) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 1 || (poke != 0 && cyc == poke + 1)) in_valid = 1'b0;
            if (poke != 0 && cyc == poke) begin
                in_valid = 1'b1;
                aluctl   = ADD;
                A        = 32'd1;
                B        = 32'd1;
            end
            if (abort_at != 0 && cyc == abort_at) rst = 1'b1;
            if (abort_at != 0 && cyc == abort_at + 1) begin
                rst = 1'b0;
                chk({nm, " abort ready"}, 32'(ready), 32'd0);
                chk({nm, " abort C"}, C, 32'd0);
                chk({nm, " abort hi"}, hi, 32'd0);
                chk({nm, " abort ovf"}, 32'(ovf), 32'd0);
                chk({nm, " abort busy"}, 32'(busy), 32'd0);
                chk({nm, " abort in_ready"}, 32'(in_ready), 32'd1);
                return;
            end
            if (ready === 1'b1) seen = 1'b1;
            if (busy !== (cyc < lat)) bad++;
            if (in_ready !== !busy) bad++;
        end
        chk({nm, " latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(lat));
        chk({nm, " busy_window"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        rst      = 1'b1;
        in_valid = 1'b1;
        aluctl   = ADD;
        A        = 32'd1;
        B        = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 32'(ready), 32'd0);
        chk("reset C", C, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        issue(ADD,  32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 1'b1, 1, 0, 0, "add_ovf");
        @(negedge clk);
        issue(6'd17, 32'h1234_5678, 32'h1, 32'h0, 32'h0, 1'b0, 1, 0, 0, "illegal17");
        @(negedge clk);
        issue(ADDU, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0, 1'b0, 1, 0, 0, "addu");
        @(negedge clk);
        issue(SUB,  32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h0, 1'b1, 1, 0, 0, "sub_ovf");
        @(negedge clk);
        issue(SUBU, 32'h5, 32'h7, 32'hFFFF_FFFE, 32'h0, 1'b0, 1, 0, 0, "subu");
        @(negedge clk);
        issue(AND_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 32'h0, 1'b0, 1, 0, 0, "and");
        @(negedge clk);
        issue(OR_,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 32'h0, 1'b0, 1, 0, 0, "or");
        @(negedge clk);
        issue(XOR_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 32'h0, 1'b0, 1, 0, 0, "xor");
        @(negedge clk);
        issue(NOR_, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F, 32'h0, 1'b0, 1, 0, 0, "nor");
        @(negedge clk);
        issue(SLL,  32'h1, 32'h21, 32'h2, 32'h0, 1'b0, 1, 0, 0, "sll_mask");
        @(negedge clk);
        issue(SRL,  32'h8000_0000, 32'h4, 32'h0800_0000, 32'h0, 1'b0, 1, 0, 0, "srl");
        @(negedge clk);
        issue(SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 32'h0, 1'b0, 1, 0, 0, "sra");
        @(negedge clk);
        issue(SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 32'h0, 1'b0, 1, 0, 0, "slt");
        @(negedge clk);
        issue(SLTU, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 0, 0, "sltu");
        @(negedge clk);
        issue(SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 1'b0, 1, 0, 0, "sltu_neg");
        @(negedge clk);

        issue(MULT, 32'hFFFF_FFFD, 32'h5, 32'hFFFF_FFF1, 32'hFFFF_FFFF, 1'b0, 33, 5, 0, "mult");
        @(negedge clk);
        issue(DIV,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33, 0, 0, "div_neg");
        @(negedge clk);
        issue(ADD,  32'h1, 32'h2, 32'h3, 32'hFFFF_FFFF, 1'b0, 1, 0, 0, "add_hi_hold");
        @(negedge clk);
        issue(DIVU, 32'h7, 32'h0, 32'hFFFF_FFFF, 32'h7, 1'b0, 33, 0, 0, "divu_by0");
        @(negedge clk);
        issue(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 33, 0, 0, "div_min");
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 1'b0, 33, 0, 0, "multu_b2b");
        @(negedge clk);
        issue(DIV,  32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0, 33, 0, 0, "div_negb");
        @(negedge clk);
        issue(6'd63, 32'h5, 32'h5, 32'h0, 32'h1, 1'b0, 1, 0, 0, "illegal63");
        @(negedge clk);
        issue(MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1, 1'b0, 33, 0, 0, "multu_2p32");
        @(negedge clk);

        issue(MULT, 32'h3, 32'h3, 32'h9, 32'h0, 1'b0, 33, 0, 10, "mult_abort");
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) pulses++;
        end
        chk("abort no_ready", 32'(pulses), 32'd0);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
